seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse arithmetic path to the team's ripple adder cells.
- Each iteration performs one trial subtraction on a ripple subtractor built from full-adder cells: inverted subtrahend, carry-in 1.
- Sits beside the adder datapath and is driven by a start/done handshake from the lab top-level controller.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request a division; sampled only when not busy.
- dividend  input  WIDTH  unsigned dividend, captured on an accepted start.
- divisor  input  WIDTH  unsigned divisor, captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- quotient  output  WIDTH  result quotient; holds until the next accepted start.
- remainder  output  WIDTH  result remainder; holds until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; holds with the result.

Behaviour:
- Reset: rst_n=0 at a clock edge forces state IDLE, the iteration counter to 0, and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset has priority over start and aborts any operation in flight; no done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE / DONE with start=1:
  - Capture the operands: the quotient register takes dividend, the partial remainder (WIDTH+1 bits) is cleared, the divisor is captured zero-extended, and the counter is set to WIDTH.
  - If divisor==0, go to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
  - Otherwise clear div_by_zero and go to RUN.
- IDLE with start=0: stay in IDLE; outputs hold.
- RUN, each cycle:
  - Left-shift {rem, quo} by one.
  - Trial = shifted rem minus divisor, WIDTH+1 bits.
  - If the trial borrow-out shows non-negative, rem = trial and the new quotient LSB = 1; else rem is unchanged and the LSB = 0.
  - Decrement the counter. When the counter reaches 1 before decrementing, go to DONE.
- DONE: done=1 for exactly one cycle. With no start, go to IDLE. A start in DONE is accepted exactly as in IDLE, so back-to-back operations are possible.
- busy=1 in RUN only. start while busy is ignored, with no effect on the operation in progress.
- Latency, taking the accepting edge as edge 0:
  - Nonzero divisor: done is high in the cycle after edge WIDTH+1, i.e. WIDTH RUN cycles plus the DONE cycle.
  - Zero divisor: done is high after edge 1.
- quotient and remainder are registered, change only on entry to DONE, and are stable while done=1 and afterwards.
- Operand inputs may change freely after an accepted start.
- Arithmetic is unsigned only. The remainder is always < divisor for a nonzero divisor, and quotient*divisor + remainder = dividend.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the zero-divisor quotient constant (all ones at WIDTH).
- One sub-module, ripple_subtractor:
  - parameterized WIDTH+1 bits, combinational, built from a chain of full-adder cells;
  - outputs the difference and no_borrow (the final carry-out).
- The top block holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=4, dividend=13, divisor=4, start pulse -> busy high for 4 cycles, done pulse at cycle 5, quotient=3, remainder=1, div_by_zero=0.
- Sweep of 15/1, 5/7, 0/3, 15/15 -> (15,0), (0,5), (0,0), (1,0); exhaustive 16x15 nonzero-divisor sweep checked against a reference model.
- dividend=9, divisor=0 -> done after 1 cycle, quotient=15, remainder=9, div_by_zero=1, busy never high.
- Start 13/4, then start 2/1 with changed operands on cycle 2 while busy -> second start ignored, result 3 r 1; operand changes have no effect.
- Start 13/4, rst_n=0 on cycle 2 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh 7/2 then yields 3 r 1.
- Start 13/4, then start 14/3 during the done cycle -> first result 3 r 1, then busy rises immediately and the second result is 4 r 2 five cycles later.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t         : FSM state encoding (idle / iterating / result pulse)
//   MaxWidth        : widest operand the zero-divisor constant supports
//   ZeroDivQuotient : quotient reported for a zero divisor (all ones),
//                     sliced down to the operand width by the user
package seq_divider_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

    localparam int unsigned MaxWidth = 64;

    localparam logic [MaxWidth-1:0] ZeroDivQuotient = '1;

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// Combinational ripple subtractor built from a chain of full-adder cells.
// Computes a - b as a + ~b + 1.
//   a, b      : WIDTH-bit unsigned operands
//   diff      : WIDTH-bit difference (modulo 2**WIDTH)
//   no_borrow : final carry-out; 1 when a >= b
module ripple_subtractor #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_inv;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign no_borrow = carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock and synchronous active-low reset
//   start               : request a division (ignored while busy)
//   dividend, divisor   : operands, captured on an accepted start
//   busy                : high while iterating
//   done                : one-cycle pulse when the result is valid
//   quotient, remainder : registered result, updated only on entry to done
//   div_by_zero         : set with done when the captured divisor was 0
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] quo_shifted;
    logic             unused_rem_msb;

    // The partial remainder stays below the divisor, so its MSB is always
    // zero before the shift and only the low WIDTH bits feed the next step.
    assign shifted        = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign quo_shifted    = quo_q << 1;
    assign unused_rem_msb = rem_q[WIDTH];

    ripple_subtractor #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a        (shifted),
        .b        (dvs_q),
        .diff     (trial),
        .no_borrow(no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (start) begin
                    quo_d = dividend;
                    rem_d = '0;
                    dvs_d = {1'b0, divisor};
                    cnt_d = CntW'(WIDTH);
                    if (divisor == '0) begin
                        state_d     = StDone;
                        quotient_d  = ZeroDivQuotient[WIDTH-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StRun;
                        dbz_d   = 1'b0;
                    end
                end
            end
            StRun: begin
                // Restoring step: keep the trial only when it did not borrow.
                rem_d = no_borrow ? trial : shifted;
                quo_d = quo_shifted | WIDTH'(no_borrow);
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_d;
                    remainder_d = rem_d[WIDTH-1:0];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
